// File: rtl/multiport_reg_file.sv
// Register file with two byte-masked write ports and NUM_RD combinational read ports.
// Optional hardwired-zero register 0 and same-cycle write-to-read forwarding.
module multiport_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     regWrite0,
  input  logic [ADDR_W-1:0]        writeReg0,
  input  logic [DATA_W-1:0]        writeData0,
  input  logic [DATA_W/8-1:0]      byteEn0,
  input  logic                     regWrite1,
  input  logic [ADDR_W-1:0]        writeReg1,
  input  logic [DATA_W-1:0]        writeData1,
  input  logic [DATA_W/8-1:0]      byteEn1,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic                     writeConflict
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BYTES  = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];

  logic wrEn0;
  logic wrEn1;
  logic sameAddr;

  // A write with no enabled bytes, or aimed at the hardwired zero register, is no write at all.
  assign wrEn0    = regWrite0 && (|byteEn0) && !((ZERO_REG != 0) && (writeReg0 == '0));
  assign wrEn1    = regWrite1 && (|byteEn1) && !((ZERO_REG != 0) && (writeReg1 == '0));
  assign sameAddr = (writeReg0 == writeReg1);

  // Byte-wise merge of both ports onto an old value; port 1 wins on shared bytes.
  function automatic logic [DATA_W-1:0] mergeBytes(
    input logic [DATA_W-1:0] oldVal,
    input logic              hit0,
    input logic              hit1,
    input logic [DATA_W-1:0] data0,
    input logic [BYTES-1:0]  be0,
    input logic [DATA_W-1:0] data1,
    input logic [BYTES-1:0]  be1
  );
    logic [DATA_W-1:0] res;
    res = oldVal;
    for (int b = 0; b < BYTES; b++) begin
      if (hit1 && be1[b]) begin
        res[b*8 +: 8] = data1[b*8 +: 8];
      end else if (hit0 && be0[b]) begin
        res[b*8 +: 8] = data0[b*8 +: 8];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetN) begin
      regs          <= '{default: '0};
      writeConflict <= 1'b0;
    end else begin
      if (wrEn0) begin
        regs[writeReg0] <= mergeBytes(regs[writeReg0], 1'b1, wrEn1 && sameAddr,
                                      writeData0, byteEn0, writeData1, byteEn1);
      end
      if (wrEn1) begin
        regs[writeReg1] <= mergeBytes(regs[writeReg1], wrEn0 && sameAddr, 1'b1,
                                      writeData0, byteEn0, writeData1, byteEn1);
      end
      writeConflict <= wrEn0 && wrEn1 && sameAddr;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic              hit0;
    logic              hit1;
    readData = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      addr = readReg[k*ADDR_W +: ADDR_W];
      hit0 = wrEn0 && (writeReg0 == addr);
      hit1 = wrEn1 && (writeReg1 == addr);
      if ((BYPASS != 0) && resetN && (hit0 || hit1)) begin
        readData[k*DATA_W +: DATA_W] = mergeBytes(regs[addr], hit0, hit1,
                                                  writeData0, byteEn0, writeData1, byteEn1);
      end else begin
        readData[k*DATA_W +: DATA_W] = regs[addr];
      end
      // Register 0 is forced to zero even before the first reset and is never forwarded.
      if ((ZERO_REG != 0) && (addr == '0)) begin
        readData[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file: forwarding and non-forwarding instances share stimulus.
module tb_multiport_reg_file;

  logic        clk = 1'b0;
  logic        resetN;
  logic        regWrite0, regWrite1;
  logic [4:0]  writeReg0, writeReg1;
  logic [31:0] writeData0, writeData1;
  logic [3:0]  byteEn0, byteEn1;
  logic [9:0]  readReg;
  logic [63:0] readData, readDataNb;
  logic        writeConflict, writeConflictNb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiport_reg_file #(.BYPASS(1)) dut (
    .clk(clk), .resetN(resetN),
    .regWrite0(regWrite0), .writeReg0(writeReg0), .writeData0(writeData0), .byteEn0(byteEn0),
    .regWrite1(regWrite1), .writeReg1(writeReg1), .writeData1(writeData1), .byteEn1(byteEn1),
    .readReg(readReg), .readData(readData), .writeConflict(writeConflict)
  );

  multiport_reg_file #(.BYPASS(0)) dutNb (
    .clk(clk), .resetN(resetN),
    .regWrite0(regWrite0), .writeReg0(writeReg0), .writeData0(writeData0), .byteEn0(byteEn0),
    .regWrite1(regWrite1), .writeReg1(writeReg1), .writeData1(writeData1), .byteEn1(byteEn1),
    .readReg(readReg), .readData(readDataNb), .writeConflict(writeConflictNb)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] expNb0;
    logic        expConf;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    regWrite0  = v.we0; writeReg0 = v.wa0; writeData0 = v.wd0; byteEn0 = v.be0;
    regWrite1  = v.we1; writeReg1 = v.wa1; writeData1 = v.wd1; byteEn1 = v.be1;
    readReg    = {v.ra1, v.ra0};
  endtask

  initial begin
    // we0 wa0 wd0 be0 | we1 wa1 wd1 be1 | ra0 ra1 | exp0 exp1 expNb0 expConf
    vecs[0]  = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd16, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1, 5'd0,  32'h4,        4'hF, 0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd16, 32'h0,        32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1, 5'd16, 32'h6,        4'hF, 0, 5'd0,  32'h0,        4'h0, 5'd16, 5'd0,  32'h6,        32'h0,        32'h0,        1'b0};
    vecs[3]  = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd16, 5'd0,  32'h6,        32'h0,        32'h6,        1'b0};
    vecs[4]  = '{1, 5'd3,  32'hAABBCCDD, 4'hF, 0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd3,  32'hAABBCCDD, 32'hAABBCCDD, 32'h0,        1'b0};
    vecs[5]  = '{1, 5'd3,  32'h11223344, 4'h5, 0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd16, 32'hAA22CC44, 32'h6,        32'hAABBCCDD, 1'b0};
    vecs[6]  = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd3,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
    vecs[7]  = '{1, 5'd5,  32'h11111111, 4'hF, 1, 5'd5,  32'h22222222, 4'h3, 5'd5,  5'd0,  32'h11112222, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd3,  32'h11112222, 32'hAA22CC44, 32'h11112222, 1'b1};
    vecs[9]  = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd5,  32'h11112222, 32'h11112222, 32'h11112222, 1'b0};
    vecs[10] = '{1, 5'd8,  32'h12345678, 4'h0, 1, 5'd8,  32'hFFFFFFFF, 4'h0, 5'd8,  5'd8,  32'h0,        32'h0,        32'h0,        1'b0};
    vecs[11] = '{1, 5'd10, 32'hA0A0A0A0, 4'hF, 1, 5'd11, 32'hB0B0B0B0, 4'hF, 5'd10, 5'd11, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'h0,        1'b0};
    vecs[12] = '{1, 5'd0,  32'hFFFFFFFF, 4'hF, 1, 5'd0,  32'h1,        4'hF, 5'd0,  5'd10, 32'h0,        32'hA0A0A0A0, 32'h0,        1'b0};
    vecs[13] = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd11, 5'd8,  32'hB0B0B0B0, 32'h0,        32'hB0B0B0B0, 1'b0};
    vecs[14] = '{0, 5'd0,  32'h0,        4'h0, 1, 5'd7,  32'hDEADBEEF, 4'hF, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[15] = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[16] = '{1, 5'd5,  32'hAAAAAAAA, 4'hC, 1, 5'd5,  32'h55555555, 4'h6, 5'd5,  5'd5,  32'hAA555522, 32'hAA555522, 32'h11112222, 1'b0};
    vecs[17] = '{0, 5'd0,  32'h0,        4'h0, 0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd7,  32'hAA555522, 32'hDEADBEEF, 32'hAA555522, 1'b1};

    resetN = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("reset_conflict", {31'b0, writeConflict}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_rd0", i), readData[31:0], vecs[i].exp0);
      check($sformatf("v%0d_rd1", i), readData[63:32], vecs[i].exp1);
      check($sformatf("v%0d_nb_rd0", i), readDataNb[31:0], vecs[i].expNb0);
      check($sformatf("v%0d_conf", i), {31'b0, writeConflict}, {31'b0, vecs[i].expConf});
    end

    // Colliding write to reg 9 sets the conflict flag; reset on the following edge clears all.
    @(negedge clk);
    drive('{1, 5'd9, 32'h5, 4'hF, 1, 5'd9, 32'h5, 4'hF, 5'd9, 5'd16, 32'h0, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    drive('{1, 5'd9, 32'h9, 4'hF, 1, 5'd9, 32'h9, 4'hF, 5'd9, 5'd16, 32'h0, 32'h0, 32'h0, 1'b0});
    resetN = 1'b0;
    #1;
    check("rst_conf_before", {31'b0, writeConflict}, 32'h1);
    check("rst_no_bypass", readData[31:0], 32'h5);
    check("rst_reg16_before", readData[63:32], 32'h6);
    @(negedge clk);
    resetN = 1'b1;
    drive('{0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd16, 32'h0, 32'h0, 32'h0, 1'b0});
    #1;
    check("rst_reg9_cleared", readData[31:0], 32'h0);
    check("rst_reg16_cleared", readData[63:32], 32'h0);
    check("rst_conf_cleared", {31'b0, writeConflict}, 32'h0);
    check("rst_nb_reg9", readDataNb[31:0], 32'h0);
    @(negedge clk);
    drive('{1, 5'd9, 32'h9, 4'hF, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0});
    #1;
    check("post_rst_nb_old", readDataNb[31:0], 32'h0);
    @(negedge clk);
    drive('{0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0});
    #1;
    check("post_rst_write", readData[31:0], 32'h9);
    check("post_rst_write_nb", readDataNb[31:0], 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 SHALL be hardwired to zero.
REQ-005 Parameter BYPASS, default 1: when 1, same-cycle write data SHALL be forwarded to matching reads.
REQ-006 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-007 resetN  input  1: reset, synchronous and active-low.
REQ-008 regWrite0  input  1: write enable, write port 0.
REQ-009 writeReg0  input  ADDR_W: write address, port 0.
REQ-010 writeData0  input  DATA_W: write data, port 0.
REQ-011 byteEn0  input  DATA_W/8: byte enables, port 0; bit i selects bits 8i+7:8i.
REQ-012 regWrite1, writeReg1, writeData1, byteEn1: write port 1, same widths and meaning as port 0.
REQ-013 readReg  input  NUM_RD*ADDR_W: packed read addresses; port k occupies bits k*ADDR_W+ADDR_W-1:k*ADDR_W.
REQ-014 readData  output  NUM_RD*DATA_W: packed read data, packed the same way.
REQ-015 writeConflict  output  1: registered flag; both write ports targeted the same register in the previous cycle.

Function
REQ-016 Reads SHALL be combinational: readData port k reflects register readReg[k] in the same cycle, with no clock latency.
REQ-017 A write SHALL take effect at the rising edge when regWriteN=1 and resetN=1; only bytes with byteEnN=1 change; the other bytes keep their value.
REQ-018 regWriteN=1 with byteEnN=0 SHALL leave the register unchanged and SHALL NOT be counted as a write for conflict purposes.
REQ-019 With ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0 and are never bypassed.
REQ-020 Simultaneous writes to the same register: port 1 bytes SHALL override port 0 bytes where both enable the byte; bytes enabled by only one port SHALL take that port's data.
REQ-021 Simultaneous writes to different registers SHALL both complete in the same edge.
REQ-022 writeConflict SHALL be 1 for exactly the cycle after an edge at which both ports wrote (non-zero byte enables) the same address; 0 otherwise.
REQ-023 With ZERO_REG=1, colliding writes to address 0 SHALL NOT set writeConflict.
REQ-024 With BYPASS=1 and resetN=1: a read whose address matches an active write in the current cycle SHALL return the post-edge merged value per REQ-017/020, combinationally.
REQ-025 With BYPASS=0: reads SHALL return the pre-edge stored value; the new value is visible the cycle after the edge.
REQ-026 While resetN=0, bypass SHALL be suppressed; reads return stored array contents.
REQ-027 Any number of read ports SHALL be able to read the same address concurrently with identical results.

Reset
REQ-028 At a rising edge with resetN=0, every register SHALL be cleared to 0 and writeConflict SHALL be cleared to 0; any concurrent writes are discarded.
REQ-029 Reset asserted mid-operation SHALL take priority over all writes at that edge; the first write after deassertion SHALL be accepted at the next edge with resetN=1.
REQ-030 Before the first reset edge, register contents are undefined; the bench SHALL apply reset first.

Verification
REQ-031 Reset, then readReg = {5'd16, 5'd0} -> readData = 0 on both ports; writeConflict = 0.
REQ-032 Port 0 writes 4 to reg 0 and 6 to reg 16 on successive edges with byteEn0=4'hF -> reg 0 reads 0, reg 16 reads 6.
REQ-033 Reg 3 = 32'hAABBCCDD; port 0 writes 32'h11223344 with byteEn0=4'b0101 -> reg 3 reads 32'hAA22CC44.
REQ-034 Same edge: port 0 writes 32'h11111111 (byteEn 4'hF) and port 1 writes 32'h22222222 (byteEn 4'b0011) to reg 5 -> reg 5 = 32'h11112222; writeConflict = 1 for one cycle, then 0.
REQ-035 BYPASS=1: port 1 writes 32'hDEADBEEF to reg 7 while read port 0 addresses reg 7 -> readData = 32'hDEADBEEF before the edge; BYPASS=0 -> old value before the edge, new value after it.
REQ-036 Reg 9 holds 32'h5; resetN=0 at the same edge as a write of 32'h9 to reg 9 -> reg 9 reads 0 after the edge; the next write after resetN=1 is accepted.
